fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage pipeline, directly upstream of decode. Holds the PC and issues word requests to instruction memory over a valid/ready channel. Buffers in-order responses in a small queue and presents instruction, PC and PC+4 to the IF/ID boundary with a valid/ready handshake. Accepts redirects from branch/jump resolution and squashes all stale fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QUEUE_DEPTH, 2, instruction queue entries; power of two, 2..8
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid, one per accepted request, in order, latency ≥1 cycle
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  taken branch / jump from execute
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 0)
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode not stalled
- id_instr  out  32  instruction; 32'h0000_0013 (NOP) when id_valid=0
- id_pc  out  32  address of id_instr
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32

## Operation
- Reset: fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0; id_valid=0, id_instr=NOP, id_pc=0, id_pc_plus4=4, imem_req_valid=0, imem_req_addr=RESET_PC.
- Credit rule: imem_req_valid = !redirect_valid && (queue_count + outstanding < QUEUE_DEPTH); guarantees every response has a slot, so imem_rsp has no ready.
- Request accept (valid&&ready): fetch_pc += 4 (wraps at 2^32), outstanding += 1; queue entry records its PC at response time from an in-order PC shadow.
- imem_req_addr stays stable while valid and not accepted; the only permitted change is a redirect.
- Response: if drop>0, discard and drop -= 1; else enqueue {instr, pc}. outstanding -= 1 either way.
- Decode transfer on id_valid&&id_ready dequeues head.
- Redirect cycle: queue flushed, id_valid forced 0, no request issued; fetch_pc←{redirect_pc[31:2],2'b00}; drop ← outstanding − (rsp_valid this cycle); outstanding counts unchanged semantics. A response in the redirect cycle is discarded.
- Back-to-back redirects: the later one wins; drop accumulates correctly.
- Simultaneous enqueue and dequeue on full queue is legal only because credit rule prevents overflow; enqueue on empty with dequeue same cycle follows Configuration.

## Timing
- First request: cycle after rst_n deasserts.
- Without bypass: rsp at cycle N → id_valid at N+1. Redirect at cycle N → first request at redirect_pc at N+1.
- Sustained throughput: one instruction/cycle when memory latency ≤ QUEUE_DEPTH−1 and id_ready=1.
- rst_n assertion mid-operation clears all state immediately; responses arriving after reset release for pre-reset requests are undefined (memory is reset together).

## Configuration
- FETCH_BYPASS_EN defined: when queue empty and a non-dropped response arrives, id_valid/id_instr/id_pc driven combinationally from the response that cycle; if id_ready=1 it is consumed and not enqueued. Latency rsp→decode = 0 cycles.
- Undefined: all responses pass through the queue; latency 1 cycle; no combinational imem→id path.

## Structure
- Shared riscv_pkg: NOP_INSTR constant (32'h0000_0013), XLEN=32, fetch entry struct {instr, pc}.
- Sub-module fetch_queue: synchronous FIFO of fetch entries, parameter DEPTH, flush input, count output; pointers wrap modulo DEPTH.
- Counters outstanding/drop width $clog2(QUEUE_DEPTH+1).

## Test plan
- Reset, imem_req_ready=1, latency 1, id_ready=1 → requests 0x0,0x4,0x8…; id_pc 0x0 then +4 each cycle, id_pc_plus4 = id_pc+4.
- id_ready=0 for 10 cycles → at most QUEUE_DEPTH entries held, imem_req_valid drops; release → instructions delivered in order, none lost or duplicated.
- Two requests outstanding, redirect to 0x103 → both stale responses dropped, next id_pc=0x100.
- Redirect in same cycle as response → that response discarded, id_valid=0 that cycle.
- imem_req_ready=0 for 5 cycles → imem_req_addr held constant; fetch_pc at 0xFFFF_FFFC wraps to 0x0.
- With FETCH_BYPASS_EN, empty queue, rsp at cycle N → id_valid=1 at N; without → at N+1.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the pipeline front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical no-op (addi x0, x0, 0) shown to decode when idle
//   fetch_entry_t : one fetched instruction together with its address
//   word_align    : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of fetch entries sitting between instruction memory and
// decode. Pointers wrap modulo DEPTH. A flush empties the queue in one cycle
// and takes priority over push/pop.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : discard all entries
//   push         : write push_entry at the tail (caller guarantees not full)
//   push_entry   : entry to write
//   pop          : remove the head entry (caller guarantees not empty)
//   head_entry   : current head entry (undefined when empty)
//   count        : number of valid entries
//   empty        : count == 0
// -----------------------------------------------------------------------------
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    entries [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    assign head_entry = entries[rd_ptr];
    assign count      = count_q;
    assign empty      = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Holds the fetch PC, issues word requests to
// instruction memory, buffers in-order responses and hands instructions to
// decode with a valid/ready handshake. Redirects flush the queue and cause
// every response still in flight to be dropped.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
//   defined   : a live response arriving while the queue is empty is shown to
//               decode in the same cycle and, if taken, never enqueued.
//   undefined : every response goes through the queue (1-cycle latency, no
//               combinational path from imem to decode).
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      : fetch request channel
//   imem_rsp_valid/data            : in-order responses, one per request
//   redirect_valid/pc              : taken branch / jump target from execute
//   id_valid/ready                 : handshake towards decode
//   id_instr, id_pc, id_pc_plus4   : instruction and its address (+4)
// -----------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int SW = $clog2(QUEUE_DEPTH);

    // Control state
    logic          running;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    // PC shadow: addresses of accepted requests, popped by every response
    logic [31:0]   shadow_pc [QUEUE_DEPTH];
    logic [SW-1:0] shadow_wr;
    logic [SW-1:0] shadow_rd;

    // Queue interface
    fetch_entry_t  q_head;
    fetch_entry_t  q_push_entry;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;

    logic          req_fire;
    logic          rsp_live;
    logic          byp_valid;
    logic [CW:0]   inflight;
    logic [31:0]   rsp_pc;

    function automatic logic [SW-1:0] shadow_inc(input logic [SW-1:0] ptr);
        return (ptr == SW'(QUEUE_DEPTH - 1)) ? '0 : ptr + SW'(1);
    endfunction

    // Credit: queued plus in-flight never exceeds the queue size, so every
    // response is guaranteed a slot and the response channel needs no ready.
    assign inflight       = (CW+1)'(q_count) + (CW+1)'(outstanding);
    assign imem_req_valid = running && !redirect_valid &&
                            (inflight < (CW+1)'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is live only if it belongs to the current fetch stream and
    // does not coincide with a redirect.
    assign rsp_pc   = shadow_pc[shadow_rd];
    assign rsp_live = imem_rsp_valid && (drop == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign byp_valid = rsp_live && q_empty;
`else
    assign byp_valid = 1'b0;
`endif

    always_comb begin
        id_valid = 1'b0;
        id_instr = NOP_INSTR;
        id_pc    = 32'h0000_0000;
        if (!redirect_valid) begin
            if (!q_empty) begin
                id_valid = 1'b1;
                id_instr = q_head.instr;
                id_pc    = q_head.pc;
            end else if (byp_valid) begin
                id_valid = 1'b1;
                id_instr = imem_rsp_data;
                id_pc    = rsp_pc;
            end
        end
    end

    assign id_pc_plus4 = id_pc + 32'd4;

    assign q_pop        = id_valid && id_ready && !q_empty;
    assign q_push       = rsp_live && !(byp_valid && id_ready);
    assign q_push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .head_entry (q_head),
        .count      (q_count),
        .empty      (q_empty)
    );

    // Fetch PC, request bookkeeping and drop accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            shadow_wr   <= '0;
            shadow_rd   <= '0;
        end else begin
            running <= 1'b1;

            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            // Everything still in flight after this cycle is stale once a
            // redirect is seen; a response in the redirect cycle is itself
            // discarded and therefore not counted again.
            if (redirect_valid) begin
                drop <= outstanding - CW'(imem_rsp_valid);
            end else if (imem_rsp_valid && (drop != '0)) begin
                drop <= drop - CW'(1);
            end

            if (req_fire) begin
                shadow_wr <= shadow_inc(shadow_wr);
            end
            if (imem_rsp_valid) begin
                shadow_rd <= shadow_inc(shadow_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            shadow_pc[shadow_wr] <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          QD     = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    fetch_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Instruction memory contents: a bijective scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F00};
    endfunction

    // Memory model: requests accepted in cycle c answer in cycle c+lat, in order
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc = 0;
    int    lat = 1;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Behavioural model of the fetch stream: where fetch should be asking,
    // which PC decode must see next, and how many requests memory still owes.
    logic [31:0]   exp_fetch = RST_PC;
    logic [31:0]   exp_id    = RST_PC;
    int            outstanding_tb = 0;
    logic          hold_prev = 1'b0;
    logic [31:0]   hold_addr = 32'h0;
    int            first_rsp = -1;
    int            first_idv = -1;
    logic [31:0]   seen_pc[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (redirect_valid) begin
                    check("redirect_no_req", {31'b0, imem_req_valid}, 32'd0);
                    check("redirect_id_valid", {31'b0, id_valid}, 32'd0);
                    if (imem_rsp_valid) outstanding_tb--;
                    exp_fetch = {redirect_pc[31:2], 2'b00};
                    exp_id    = {redirect_pc[31:2], 2'b00};
                    hold_prev = 1'b0;
                end else begin
                    if (hold_prev) begin
                        check("hold_valid", {31'b0, imem_req_valid}, 32'd1);
                        check("hold_addr", imem_req_addr, hold_addr);
                    end
                    if (imem_req_valid) begin
                        check("req_addr", imem_req_addr, exp_fetch);
                        if (imem_req_ready) begin
                            pend.push_back('{imem_req_addr, cyc + lat});
                            exp_fetch      = exp_fetch + 32'd4;
                            outstanding_tb++;
                        end
                    end
                    hold_prev = imem_req_valid && !imem_req_ready;
                    hold_addr = imem_req_addr;
                    if (imem_rsp_valid) begin
                        outstanding_tb--;
                        if (first_rsp < 0) first_rsp = cyc;
                    end
                    if (id_valid) begin
                        if (first_idv < 0) first_idv = cyc;
                        check("id_pc", id_pc, exp_id);
                        check("id_instr", id_instr, mem_word(exp_id));
                        check("id_pc_plus4", id_pc_plus4, exp_id + 32'd4);
                        if (id_ready) begin
                            seen_pc.push_back(id_pc);
                            exp_id = exp_id + 32'd4;
                        end
                    end else begin
                        check("idle_nop", id_instr, NOP);
                    end
                end
                check("outstanding_bound", {31'b0, (outstanding_tb <= QD)}, 32'd1);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_seen(input string name, input int idx, input logic [31:0] req);
        if (idx < seen_pc.size()) begin
            check(name, seen_pc[idx], req);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s actual=<none delivered> required=%h", name, req);
        end
    endtask

    int          idx;
    int          n_before;
    logic        hit;
    logic [39:0] rdy_pat;
    int          exp_lat;

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        #12;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'h4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential fetch, latency 1, decode always ready
        wait_cycles(20);
        check_seen("seq_pc0", 0, 32'h0);
        check_seen("seq_pc1", 1, 32'h4);
        check_seen("seq_pc2", 2, 32'h8);
`ifdef FETCH_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 1;
`endif
        check("rsp_to_id_latency", first_idv - first_rsp, exp_lat);

        // Decode stall: queue fills, requests stop, nothing delivered
        id_ready = 1'b0;
        n_before = seen_pc.size();
        wait_cycles(10);
        check("stall_req_stops", {31'b0, imem_req_valid}, 32'd0);
        check("stall_no_delivery", seen_pc.size(), n_before);
        id_ready = 1'b1;
        wait_cycles(10);
        check_seen("stall_resume_order", n_before, seen_pc[n_before - 1] + 32'd4);

        // Two stale requests in flight, redirect to a misaligned target
        lat = 3;
        wait_cycles(8);
        for (int i = 0; i < 20 && outstanding_tb != 2; i++) wait_cycles(1);
        check("two_outstanding", outstanding_tb, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        idx            = seen_pc.size();
        wait_cycles(1);
        redirect_valid = 1'b0;
        wait_cycles(15);
        check_seen("redirect_target", idx, 32'h0000_0100);
        check_seen("redirect_next", idx + 1, 32'h0000_0104);

        // Redirect coinciding with a response
        lat = 1;
        wait_cycles(6);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (imem_rsp_valid) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0040;
                hit            = 1'b1;
            end
        end
        check("redirect_on_rsp_found", {31'b0, hit}, 32'd1);
        idx = seen_pc.size();
        wait_cycles(1);
        redirect_valid = 1'b0;
        wait_cycles(10);
        check_seen("redirect_rsp_target", idx, 32'h0000_0040);

        // Memory back-pressure right after a redirect near the top of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        idx            = seen_pc.size();
        wait_cycles(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        wait_cycles(5);
        check("backpressure_addr", imem_req_addr, 32'hFFFF_FFF8);
        imem_req_ready = 1'b1;
        wait_cycles(12);
        check_seen("wrap_pc0", idx, 32'hFFFF_FFF8);
        check_seen("wrap_pc1", idx + 1, 32'hFFFF_FFFC);
        check_seen("wrap_pc2", idx + 2, 32'h0000_0000);

        // Irregular decode stalls with latency 2
        lat     = 2;
        rdy_pat = 40'hB5_3C_F0_96_A7;
        for (int i = 0; i < 40; i++) begin
            id_ready = rdy_pat[i];
            wait_cycles(1);
        end
        id_ready = 1'b1;
        wait_cycles(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
